// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier: radix-4 modified Booth, two multiplier bits per clock.
// Returns the low word of the product, a signed-overflow flag and a one-cycle ready strobe.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned PW    = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    m_q;
    logic [PW-1:0]    p_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic [PW-1:0]    m2_c;
    logic [PW-1:0]    addend_c;
    logic             sub_c;
    logic [PW-1:0]    sum_c;
    logic [PW-1:0]    p_d;
    logic [WIDTH-1:0] q_d;
    logic             q1_d;
    logic             exc_d;
    logic             last_c;

    // One Booth step: recode {Q[1:0], q_1}, add/sub the multiple, then arithmetic shift by 2.
    always_comb begin
        m2_c     = {m_q[PW-2:0], 1'b0};
        addend_c = '0;
        sub_c    = 1'b0;
        unique case ({q_q[1:0], q1_q})
            3'b001, 3'b010: addend_c = m_q;
            3'b011:         addend_c = m2_c;
            3'b100: begin
                addend_c = ~m2_c;
                sub_c    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend_c = ~m_q;
                sub_c    = 1'b1;
            end
            default:        addend_c = '0;
        endcase
        sum_c  = p_q + addend_c + PW'(sub_c);
        p_d    = {{2{sum_c[PW-1]}}, sum_c[PW-1:2]};
        q_d    = {sum_c[1:0], q_q[WIDTH-1:2]};
        q1_d   = q_q[1];
        exc_d  = (p_d != {PW{q_d[WIDTH-1]}});
        last_c = (cnt_q == CW'(STEPS - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (state_q == S_RUN) begin
                p_q   <= p_d;
                q_q   <= q_d;
                q1_q  <= q1_d;
                cnt_q <= cnt_q + CW'(1);
                if (last_c) begin
                    state_q  <= S_DONE;
                    result_q <= q_d;
                    exc_q    <= exc_d;
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                end
            end else if (ctrl_MULT) begin
                // Start accepted from IDLE or DONE; DONE start gives back-to-back operation.
                state_q <= S_RUN;
                m_q     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                p_q     <= '0;
                q_q     <= data_operandB;
                q1_q    <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomized and directed bench for booth_mult_seq against a plain-arithmetic product model.
module tb_booth_mult_seq;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_res;
    logic        prev_exc;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: full signed product, low word, and whether it fits in 32 bits.
    function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        longint pr;
        longint lo;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        pr = pa * pb;
        lo = longint'($signed(pr[31:0]));
        return {(pr != lo), pr[31:0]};
    endfunction

    // Precondition: called at a negedge. Leaves the bench at the negedge of the RDY cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int disturb);
        logic [32:0] exp;
        int n;
        int busy_cnt;
        exp = ref_mult(a, b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!data_resultRDY && n < 40) begin
            if (busy) busy_cnt++;
            if (n == 8) begin
                check("held_result", 64'(data_result), 64'(prev_res));
                check("held_exc", 64'(data_exception), 64'(prev_exc));
            end
            if (n == disturb) begin
                ctrl_MULT     = 1'b1;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end else if (n == disturb + 1) begin
                ctrl_MULT = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        check("rdy_latency", 64'(n), 64'd17);
        check("busy_cycles", 64'(busy_cnt), 64'd16);
        check("result", 64'(data_result), 64'(exp[31:0]));
        check("exception", 64'(data_exception), 64'(exp[32]));
        prev_res = exp[31:0];
        prev_exc = exp[32];
    endtask

    // One cycle after the strobe: strobe gone, machine idle, result held.
    task automatic settle_idle();
        @(negedge clock);
        check("rdy_one_cycle", 64'(data_resultRDY), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hold", 64'(data_result), 64'(prev_res));
    endtask

    initial begin
        int rdy_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        prev_res      = '0;
        prev_exc      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_exc", 64'(data_exception), 64'd0);
        check("rst_rdy", 64'(data_resultRDY), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(32'd3, 32'd4, -10);
        check("dir_3x4", 64'(data_result), 64'd12);
        settle_idle();
        run_op(-32'sd7, 32'd6, -10);                      settle_idle();
        run_op(32'h7FFF_FFFF, 32'd1, -10);                settle_idle();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -10);        settle_idle();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, -10);
        check("ovf_min_x_m1", 64'(data_exception), 64'd1);
        settle_idle();
        run_op(32'h0001_0000, 32'h0001_0000, -10);        settle_idle();
        run_op(32'h4000_0000, 32'd2, -10);                settle_idle();
        run_op(32'h8000_0000, 32'h8000_0000, -10);        settle_idle();

        // Start and operand changes during RUN are ignored.
        run_op(32'd1234, -32'sd56, 5);                    settle_idle();

        // Back-to-back: new start held in the DONE cycle.
        run_op(32'd9, 32'd11, -10);
        run_op(32'd5, -32'sd5, -10);
        check("b2b_5xm5", 64'(data_result), 64'hFFFF_FFE7);
        settle_idle();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) ra = 32'($signed(ra[9:0]));
            if (i % 4 == 1) rb = 32'($signed(rb[7:0]));
            run_op(ra, rb, -10);
            if (i % 2 == 0) settle_idle();
        end
        settle_idle();

        // Reset in the middle of a run aborts it with no strobe.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd77;
        data_operandB = 32'd88;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_result", 64'(data_result), 64'd0);
        check("mid_rst_exc", 64'(data_exception), 64'd0);
        check("mid_rst_rdy", 64'(data_resultRDY), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        reset_n  = 1'b1;
        prev_res = '0;
        prev_exc = 1'b0;
        rdy_seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
        end
        check("no_strobe_after_abort", 64'(rdy_seen), 64'd0);
        run_op(32'd2, 32'd3, -10);
        check("after_rst_2x3", 64'(data_result), 64'd6);
        settle_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
